// File: rtl/cnn_param_loader_pkg.sv
// Shared constants, bank geometry, FSM state type and fixed8 helpers for the
// CNN parameter loader.
package cnn_load_pkg;

  localparam int ADDR_W_D = 16;
  localparam int DATA_W_D = 32;
  localparam int Q_W_D    = 8;
  localparam int NBANK_D  = 15;
  localparam int CNT_W    = 15;

  localparam logic [4:0] SEL_IMG = 5'd0;
  localparam logic [4:0] SEL_K01 = 5'd1;
  localparam logic [4:0] SEL_B01 = 5'd2;
  localparam logic [4:0] SEL_K02 = 5'd3;
  localparam logic [4:0] SEL_B02 = 5'd4;
  localparam logic [4:0] SEL_K03 = 5'd5;
  localparam logic [4:0] SEL_B03 = 5'd6;
  localparam logic [4:0] SEL_K06 = 5'd7;
  localparam logic [4:0] SEL_B06 = 5'd8;
  localparam logic [4:0] SEL_K07 = 5'd9;
  localparam logic [4:0] SEL_B07 = 5'd10;
  localparam logic [4:0] SEL_K08 = 5'd11;
  localparam logic [4:0] SEL_B08 = 5'd12;
  localparam logic [4:0] SEL_K12 = 5'd13;
  localparam logic [4:0] SEL_B12 = 5'd14;
  localparam logic [4:0] SEL_MAX = 5'd14;

  localparam logic [CNT_W-1:0] BANK_SIZE [0:14] = '{
    15'd3072, 15'd756,   15'd28, 15'd7056, 15'd28,
    15'd84,   15'd28,    15'd14112, 15'd56, 15'd28224,
    15'd56,   15'd1568,  15'd56, 15'd560,  15'd10
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic signed [DATA_W_D-1:0] Q_MIN = -32'sd128;
  localparam logic signed [DATA_W_D-1:0] Q_MAX = 32'sd127;

  function automatic logic [Q_W_D-1:0] sat_q(input logic signed [DATA_W_D-1:0] v);
    logic [Q_W_D-1:0] r;
    if (v > Q_MAX) begin
      r = Q_MAX[Q_W_D-1:0];
    end else if (v < Q_MIN) begin
      r = Q_MIN[Q_W_D-1:0];
    end else begin
      r = v[Q_W_D-1:0];
    end
    return r;
  endfunction

  // Unknown bank codes report size 0 so no address can ever be in range.
  function automatic logic [CNT_W-1:0] bank_size(input logic [4:0] sel);
    logic [CNT_W-1:0] r;
    r = '0;
    for (int i = 0; i < NBANK_D; i++) begin
      if (sel == 5'(i)) begin
        r = BANK_SIZE[i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/cnn_param_loader_if.sv
// Host write port of the parameter loader: one write beat per cycle.
interface cnn_param_loader_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              wr_en;
  logic [4:0]        wr_sel;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (output wr_en, output wr_sel, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_sel, input  wr_addr, input  wr_data);
endinterface

// File: rtl/cnn_param_loader_bank_ctr.sv
// Per-bank fill counter: counts accepted beats up to the bank size and holds.
module load_bank_ctr
  import cnn_load_pkg::*;
#(
  parameter logic [CNT_W-1:0] SIZE = 15'd1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic full
);

  logic [CNT_W-1:0] cnt_r;

  // Saturating fill count; clear has priority over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (inc && (cnt_r != SIZE)) begin
      cnt_r <= cnt_r + 15'd1;
    end
  end

  assign full = (cnt_r == SIZE);

endmodule

// File: rtl/cnn_param_loader.sv
// Host-side loader: validates write beats, saturates to fixed8, drives one-hot
// bank writes, tracks bank fill and sequences the compute core.
module cnn_param_loader
  import cnn_load_pkg::*;
#(
  parameter int Q_W   = Q_W_D,
  parameter int NBANK = NBANK_D
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cnn_param_loader_if.slave     wr,
  input  logic                  start,
  input  logic                  err_clr,
  input  logic                  core_done,
  output logic [NBANK-1:0]      mem_we,
  output logic [14:0]           mem_addr,
  output logic [Q_W-1:0]        mem_data,
  output logic                  core_start,
  output logic                  busy,
  output logic                  done,
  output logic [NBANK-1:0]      loaded,
  output logic                  err_sel,
  output logic                  err_addr,
  output logic                  err_start,
  output logic                  err_busy
);

  state_e           state_r;
  logic [NBANK-1:0] mem_we_r;
  logic [14:0]      mem_addr_r;
  logic [Q_W-1:0]   mem_data_r;
  logic             core_start_r, busy_r, done_r;
  logic             err_sel_r, err_addr_r, err_start_r, err_busy_r;

  logic             sel_ok_s, addr_ok_s, run_s, accept_s;
  logic             all_loaded_s, start_ok_s, start_err_s;
  logic [CNT_W-1:0] size_s;
  logic [NBANK-1:0] onehot_s, loaded_s;

  // Beat validation and start qualification.
  always_comb begin
    sel_ok_s     = (wr.wr_sel <= SEL_MAX);
    size_s       = bank_size(wr.wr_sel);
    addr_ok_s    = sel_ok_s && (32'(wr.wr_addr) < 32'(size_s));
    run_s        = (state_r == ST_RUN);
    accept_s     = wr.wr_en && !run_s && sel_ok_s && addr_ok_s;
    all_loaded_s = &loaded_s;
    start_ok_s   = start && !run_s && all_loaded_s && !wr.wr_en;
    start_err_s  = start && !run_s && !start_ok_s;
    if (accept_s) begin
      onehot_s = {{(NBANK-1){1'b0}}, 1'b1} << wr.wr_sel;
    end else begin
      onehot_s = '0;
    end
  end

  // Only the image bank is consumed per inference; weights stay loaded.
  for (genvar g = 0; g < NBANK; g++) begin : g_ctr
    load_bank_ctr #(.SIZE(BANK_SIZE[g])) u_ctr (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (onehot_s[g]),
      .clr   ((g == int'(SEL_IMG)) ? start_ok_s : 1'b0),
      .full  (loaded_s[g])
    );
  end

  // Memory-side write register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we_r   <= '0;
      mem_addr_r <= '0;
      mem_data_r <= '0;
    end else begin
      mem_we_r <= onehot_s;
      if (accept_s) begin
        mem_addr_r <= wr.wr_addr[14:0];
        mem_data_r <= Q_W'(sat_q($signed(wr.wr_data)));
      end
    end
  end

  // Run sequencer with registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      core_start_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      core_start_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_ok_s) begin
            state_r      <= ST_RUN;
            core_start_r <= 1'b1;
            busy_r       <= 1'b1;
          end
        end
        ST_RUN: begin
          if (core_done) begin
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        ST_DONE: begin
          if (start_ok_s) begin
            state_r      <= ST_RUN;
            core_start_r <= 1'b1;
            busy_r       <= 1'b1;
            done_r       <= 1'b0;
          end else if (accept_s) begin
            state_r <= ST_IDLE;
            done_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky errors; a new event wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sel_r   <= 1'b0;
      err_addr_r  <= 1'b0;
      err_start_r <= 1'b0;
      err_busy_r  <= 1'b0;
    end else begin
      err_sel_r   <= (wr.wr_en && !run_s && !sel_ok_s) || (err_sel_r && !err_clr);
      err_addr_r  <= (wr.wr_en && !run_s && sel_ok_s && !addr_ok_s) || (err_addr_r && !err_clr);
      err_start_r <= start_err_s || (err_start_r && !err_clr);
      err_busy_r  <= (wr.wr_en && run_s) || (err_busy_r && !err_clr);
    end
  end

  assign mem_we     = mem_we_r;
  assign mem_addr   = mem_addr_r;
  assign mem_data   = mem_data_r;
  assign core_start = core_start_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign loaded     = loaded_s;
  assign err_sel    = err_sel_r;
  assign err_addr   = err_addr_r;
  assign err_start  = err_start_r;
  assign err_busy   = err_busy_r;

endmodule
